bnn_fsm: RTL and testbench

- Top-level sequencing controller for the binary neural network MNIST accelerator.
- Steps the datapath through image load, layer 1, layer 2 and layer 3, based on a run request (`mode`) and per-stage completion flags.
- Exposes its current state as a 3-bit code; the load and layer engines decode it to enable themselves.
- Pure control block: registered Moore machine, no datapath.

---
 rtl/bnn_fsm.sv | 70 +++++++
 tb/tb_bnn_fsm.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bnn_fsm.sv
// Top-level sequencing controller for the BNN MNIST accelerator.
// Registered Moore machine stepping image load and the three layer engines.
module bnn_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode,
  input  logic       load_done,
  input  logic       layer_1_done,
  input  logic       layer_2_done,
  input  logic       layer_3_done,
  output logic [2:0] state
);

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    LAYER1 = 3'd2,
    LAYER2 = 3'd3,
    LAYER3 = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t state_q;
  state_t state_d;

  // State register; reset is sampled on the clock edge and wins over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: dropping mode aborts to IDLE ahead of any done flag, and each
  // flag is only honoured in its own state so the machine moves one step per clock.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mode) state_d = LOAD;
      end
      LOAD: begin
        if (!mode)          state_d = IDLE;
        else if (load_done) state_d = LAYER1;
      end
      LAYER1: begin
        if (!mode)             state_d = IDLE;
        else if (layer_1_done) state_d = LAYER2;
      end
      LAYER2: begin
        if (!mode)             state_d = IDLE;
        else if (layer_2_done) state_d = LAYER3;
      end
      LAYER3: begin
        if (!mode)             state_d = IDLE;
        else if (layer_3_done) state_d = DONE;
      end
      DONE: begin
        if (!mode) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_bnn_fsm.sv
// Directed self-checking bench for the bnn_fsm sequencing controller.
module tb_bnn_fsm;

  logic       clk;
  logic       rst_n;
  logic       mode;
  logic       load_done;
  logic       layer_1_done;
  logic       layer_2_done;
  logic       layer_3_done;
  logic [2:0] state;

  int n_pass;
  int n_total;

  bnn_fsm dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode         (mode),
    .load_done    (load_done),
    .layer_1_done (layer_1_done),
    .layer_2_done (layer_2_done),
    .layer_3_done (layer_3_done),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flags packed as {layer_3_done, layer_2_done, layer_1_done, load_done}.
  task automatic set_flags(input logic [3:0] f);
    {layer_3_done, layer_2_done, layer_1_done, load_done} = f;
  endtask

  // Advance one rising edge and settle 1ns past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mode  = 1'b1;
    set_flags(4'b1111);
    for (int i = 0; i < 2; i++) begin
      step();
      n_total++;
      if (state !== 3'd0) $display("FAIL reset_hold[%0d]: state=%0d expected=0", i, state);
      else n_pass++;
    end
    rst_n = 1'b1;
    step();
    n_total++;
    if (state !== 3'd1) $display("FAIL reset_release: state=%0d expected=1", state);
    else n_pass++;
    mode = 1'b0;
    set_flags(4'b0000);
    step();
    n_total++;
    if (state !== 3'd0) $display("FAIL reset_to_idle: state=%0d expected=0", state);
    else n_pass++;
  endtask

  task automatic test_nominal();
    logic [3:0] fl [13];
    logic [2:0] ex [13];
    fl = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h8};
    ex = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd5};
    n_total++;
    if (state !== 3'd0) $display("FAIL nominal_start: state=%0d expected=0", state);
    else n_pass++;
    mode = 1'b1;
    for (int i = 0; i < 13; i++) begin
      set_flags(fl[i]);
      step();
      n_total++;
      if (state !== ex[i]) $display("FAIL nominal_seq[%0d]: state=%0d expected=%0d", i, state, ex[i]);
      else n_pass++;
    end
    set_flags(4'b0000);
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++;
      if (state !== 3'd5) $display("FAIL done_hold[%0d]: state=%0d expected=5", i, state);
      else n_pass++;
    end
    mode = 1'b0;
    step();
    n_total++;
    if (state !== 3'd0) $display("FAIL done_exit: state=%0d expected=0", state);
    else n_pass++;
  endtask

  task automatic test_stray_flags();
    mode = 1'b1;
    set_flags(4'b0000);
    step();
    n_total++;
    if (state !== 3'd1) $display("FAIL stray_enter_load: state=%0d expected=1", state);
    else n_pass++;
    set_flags(4'b1100);
    for (int i = 0; i < 2; i++) begin
      step();
      n_total++;
      if (state !== 3'd1) $display("FAIL stray_ignored[%0d]: state=%0d expected=1", i, state);
      else n_pass++;
    end
    set_flags(4'b1101);
    step();
    n_total++;
    if (state !== 3'd2) $display("FAIL stray_no_skip: state=%0d expected=2", state);
    else n_pass++;
    set_flags(4'b1100);
    step();
    n_total++;
    if (state !== 3'd2) $display("FAIL stray_in_layer1: state=%0d expected=2", state);
    else n_pass++;
    mode = 1'b0;
    set_flags(4'b0000);
    step();
    n_total++;
    if (state !== 3'd0) $display("FAIL stray_exit: state=%0d expected=0", state);
    else n_pass++;
  endtask

  task automatic test_flags_stuck();
    mode = 1'b1;
    set_flags(4'b1111);
    for (int i = 1; i <= 6; i++) begin
      step();
      n_total++;
      if (state !== 3'((i > 5) ? 5 : i))
        $display("FAIL stuck_step[%0d]: state=%0d expected=%0d", i, state, (i > 5) ? 5 : i);
      else n_pass++;
    end
    mode = 1'b0;
    step();
    n_total++;
    if (state !== 3'd0) $display("FAIL stuck_exit: state=%0d expected=0", state);
    else n_pass++;
  endtask

  task automatic test_abort();
    mode = 1'b1;
    set_flags(4'b1111);
    for (int i = 0; i < 3; i++) step();
    n_total++;
    if (state !== 3'd3) $display("FAIL abort_reach_layer2: state=%0d expected=3", state);
    else n_pass++;
    mode = 1'b0;
    set_flags(4'b0100);
    step();
    n_total++;
    if (state !== 3'd0) $display("FAIL abort_layer2: state=%0d expected=0", state);
    else n_pass++;
    mode = 1'b1;
    set_flags(4'b0000);
    step();
    n_total++;
    if (state !== 3'd1) $display("FAIL abort_rerun: state=%0d expected=1", state);
    else n_pass++;
    mode = 1'b0;
    set_flags(4'b0001);
    step();
    n_total++;
    if (state !== 3'd0) $display("FAIL abort_load: state=%0d expected=0", state);
    else n_pass++;
  endtask

  task automatic test_sync_reset();
    mode = 1'b1;
    set_flags(4'b1111);
    for (int i = 0; i < 4; i++) step();
    set_flags(4'b0000);
    n_total++;
    if (state !== 3'd4) $display("FAIL sreset_reach_layer3: state=%0d expected=4", state);
    else n_pass++;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    n_total++;
    if (state !== 3'd4) $display("FAIL sreset_glitch: state=%0d expected=4", state);
    else n_pass++;
    rst_n = 1'b0;
    step();
    n_total++;
    if (state !== 3'd0) $display("FAIL sreset_edge: state=%0d expected=0", state);
    else n_pass++;
    rst_n = 1'b1;
    step();
    n_total++;
    if (state !== 3'd1) $display("FAIL sreset_release: state=%0d expected=1", state);
    else n_pass++;
  endtask

  initial begin
    n_pass       = 0;
    n_total      = 0;
    rst_n        = 1'b0;
    mode         = 1'b0;
    load_done    = 1'b0;
    layer_1_done = 1'b0;
    layer_2_done = 1'b0;
    layer_3_done = 1'b0;
    #1;
    test_reset();
    test_nominal();
    test_stray_flags();
    test_flags_stuck();
    test_abort();
    mode = 1'b0;
    step();
    test_sync_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
